// File: rtl/bios_shadow_pkg.sv
// Shared types and defaults for the BIOS shadow-copy boot master.
package bios_shadow_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } bios_state_e;

  localparam int unsigned BIOS_ROM_WORDS   = 4096;
  localparam logic [31:0] BIOS_SRC_BASE    = 32'h0000_0000;
  localparam logic [31:0] BIOS_SHADOW_BASE = 32'h000F_C000;
  localparam logic [3:0]  WB_SEL_ALL       = 4'hF;

  // Byte address of a 32-bit word; wraps modulo 2^32 by construction.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/wb_single_xfer.sv
// Registered single-beat Wishbone master: request level in, bus signals out,
// qualified ack and read data back.
module wb_single_xfer #(
  parameter int DATA_W = 32,
  parameter int ADR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADR_W-1:0]  adr_i,
  input  logic [DATA_W-1:0] wdat_i,
  output logic              cyc_o,
  output logic              stb_o,
  output logic              we_o,
  output logic [ADR_W-1:0]  adr_o,
  output logic [DATA_W-1:0] dat_o,
  input  logic              ack_i,
  input  logic [DATA_W-1:0] dat_i,
  output logic              ack_o,
  output logic [DATA_W-1:0] rdat_o
);

  logic              cyc_q, stb_q, we_q;
  logic [ADR_W-1:0]  adr_q;
  logic [DATA_W-1:0] dat_q;
  logic [DATA_W-1:0] rdat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= 1'b0;
      stb_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
    end else begin
      cyc_q <= req_i;
      stb_q <= req_i;
      we_q  <= req_i & we_i;
      if (req_i) begin
        adr_q <= adr_i;
        dat_q <= wdat_i;
      end
    end
  end

  // An ack only counts while our own strobe is up.
  assign ack_o = stb_q & ack_i;

  always_ff @(posedge clk) begin
    if (ack_o) rdat_q <= dat_i;
  end

  // Bypass lets the accepting cycle forward the word without an extra stage.
  assign rdat_o = ack_o ? dat_i : rdat_q;

  assign cyc_o = cyc_q;
  assign stb_o = stb_q;
  assign we_o  = we_q;
  assign adr_o = adr_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/bios_shadow_loader.sv
// Boot-time ROM-to-shadow-RAM copier; holds the CPU in reset until the copy is done.
module bios_shadow_loader
  import bios_shadow_pkg::*;
#(
  parameter int unsigned WORDS      = BIOS_ROM_WORDS,
  parameter logic [31:0] SRC_BASE   = BIOS_SRC_BASE,
  parameter logic [31:0] DST_BASE   = BIOS_SHADOW_BASE,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [31:0] src_adr_o,
  input  logic [31:0] src_dat_i,
  output logic        src_cyc_o,
  output logic        src_stb_o,
  output logic        src_we_o,
  output logic [3:0]  src_sel_o,
  input  logic        src_ack_i,
  output logic [31:0] dst_adr_o,
  output logic [31:0] dst_dat_o,
  output logic        dst_cyc_o,
  output logic        dst_stb_o,
  output logic        dst_we_o,
  output logic [3:0]  dst_sel_o,
  input  logic        dst_ack_i,
  output logic        busy,
  output logic        done,
  output logic        cpu_rst_o
);

  localparam int unsigned     IDX_W    = $clog2(WORDS) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  bios_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             src_req, dst_req;
  logic             src_ack, dst_ack;
  logic [31:0]      src_adr_d, dst_adr_d;
  logic [31:0]      rd_word;
  logic [31:0]      src_wdat_unused, dst_rdat_unused;
  logic             busy_q, done_q, cpu_rst_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (AUTO_START || start) begin
          state_d = RD;
          idx_d   = '0;
        end
      end
      RD: begin
        if (src_ack) state_d = WR;
      end
      WR: begin
        if (dst_ack) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = RD;
          end
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Bus requests follow the next state so strobes appear from flops in the state's own cycle.
  assign src_req   = (state_d == RD);
  assign dst_req   = (state_d == WR);
  assign src_adr_d = word_addr(SRC_BASE, 32'(idx_d));
  assign dst_adr_d = word_addr(DST_BASE, 32'(idx_d));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cpu_rst_q <= 1'b1;
    end else begin
      busy_q    <= (state_d == RD) || (state_d == WR);
      done_q    <= (state_d == DONE);
      cpu_rst_q <= (state_d != DONE);
    end
  end

  wb_single_xfer #(.DATA_W(32), .ADR_W(32)) u_src (
    .clk    (clk),
    .rst    (rst),
    .req_i  (src_req),
    .we_i   (1'b0),
    .adr_i  (src_adr_d),
    .wdat_i (32'h0),
    .cyc_o  (src_cyc_o),
    .stb_o  (src_stb_o),
    .we_o   (src_we_o),
    .adr_o  (src_adr_o),
    .dat_o  (src_wdat_unused),
    .ack_i  (src_ack_i),
    .dat_i  (src_dat_i),
    .ack_o  (src_ack),
    .rdat_o (rd_word)
  );

  wb_single_xfer #(.DATA_W(32), .ADR_W(32)) u_dst (
    .clk    (clk),
    .rst    (rst),
    .req_i  (dst_req),
    .we_i   (1'b1),
    .adr_i  (dst_adr_d),
    .wdat_i (rd_word),
    .cyc_o  (dst_cyc_o),
    .stb_o  (dst_stb_o),
    .we_o   (dst_we_o),
    .adr_o  (dst_adr_o),
    .dat_o  (dst_dat_o),
    .ack_i  (dst_ack_i),
    .dat_i  (32'h0),
    .ack_o  (dst_ack),
    .rdat_o (dst_rdat_unused)
  );

  assign src_sel_o = WB_SEL_ALL;
  assign dst_sel_o = WB_SEL_ALL;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cpu_rst_o = cpu_rst_q;

endmodule

// File: tb/tb_bios_shadow_loader.sv
// Directed bench: auto-start instance (A) and manual-start, wrapping-address instance (B).
module tb_bios_shadow_loader;

  localparam logic [31:0] DST   = 32'h000F_C000;
  localparam logic [31:0] SRC_B = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a ^ 32'h5A5A_0F0F) + {a[15:0], a[31:16]};
  endfunction

  // ---------------- instance A ----------------
  logic        rst_a = 1'b1, start_a = 1'b0;
  logic [31:0] src_adr_a, src_dat_a, dst_adr_a, dst_dat_a;
  logic        src_cyc_a, src_stb_a, src_we_a, src_ack_a;
  logic        dst_cyc_a, dst_stb_a, dst_we_a, dst_ack_a;
  logic [3:0]  src_sel_a, dst_sel_a;
  logic        busy_a, done_a, cpu_rst_a;

  bios_shadow_loader #(.WORDS(4), .SRC_BASE(32'h0), .DST_BASE(DST), .AUTO_START(1'b1)) u_a (
    .clk(clk), .rst(rst_a), .start(start_a),
    .src_adr_o(src_adr_a), .src_dat_i(src_dat_a), .src_cyc_o(src_cyc_a), .src_stb_o(src_stb_a),
    .src_we_o(src_we_a), .src_sel_o(src_sel_a), .src_ack_i(src_ack_a),
    .dst_adr_o(dst_adr_a), .dst_dat_o(dst_dat_a), .dst_cyc_o(dst_cyc_a), .dst_stb_o(dst_stb_a),
    .dst_we_o(dst_we_a), .dst_sel_o(dst_sel_a), .dst_ack_i(dst_ack_a),
    .busy(busy_a), .done(done_a), .cpu_rst_o(cpu_rst_a)
  );

  int   waits_a = 0, wcnt_a = 0, wr_a = 0, ovl_a = 0, unst_a = 0, badwe_a = 0;
  logic spur_a = 1'b0, hold_a = 1'b0;
  logic [31:0] hadr_a = '0, hdat_a = '0;
  logic [31:0] log_adr_a [0:63];
  logic [31:0] log_dat_a [0:63];

  assign src_ack_a = src_stb_a | (spur_a & dst_stb_a);
  assign src_dat_a = src_stb_a ? rom_word(src_adr_a) : 32'hBAD0_BAD0;
  assign dst_ack_a = (dst_stb_a && (wcnt_a == waits_a)) || (spur_a && src_stb_a);

  always @(posedge clk) begin
    wcnt_a <= (dst_stb_a && !dst_ack_a) ? wcnt_a + 1 : 0;
    if (dst_stb_a && dst_ack_a) begin
      log_adr_a[wr_a[5:0]] <= dst_adr_a;
      log_dat_a[wr_a[5:0]] <= dst_dat_a;
      wr_a <= wr_a + 1;
    end
    if (src_stb_a && dst_stb_a) ovl_a <= ovl_a + 1;
    if (dst_stb_a && !dst_we_a) badwe_a <= badwe_a + 1;
    if (hold_a && dst_stb_a && (dst_adr_a != hadr_a || dst_dat_a != hdat_a)) unst_a <= unst_a + 1;
    hold_a <= dst_stb_a && !dst_ack_a;
    hadr_a <= dst_adr_a;
    hdat_a <= dst_dat_a;
  end

  // ---------------- instance B ----------------
  logic        rst_b = 1'b1, start_b = 1'b0;
  logic [31:0] src_adr_b, src_dat_b, dst_adr_b, dst_dat_b;
  logic        src_cyc_b, src_stb_b, src_we_b, src_ack_b;
  logic        dst_cyc_b, dst_stb_b, dst_we_b, dst_ack_b;
  logic [3:0]  src_sel_b, dst_sel_b;
  logic        busy_b, done_b, cpu_rst_b;

  bios_shadow_loader #(.WORDS(4), .SRC_BASE(SRC_B), .DST_BASE(DST), .AUTO_START(1'b0)) u_b (
    .clk(clk), .rst(rst_b), .start(start_b),
    .src_adr_o(src_adr_b), .src_dat_i(src_dat_b), .src_cyc_o(src_cyc_b), .src_stb_o(src_stb_b),
    .src_we_o(src_we_b), .src_sel_o(src_sel_b), .src_ack_i(src_ack_b),
    .dst_adr_o(dst_adr_b), .dst_dat_o(dst_dat_b), .dst_cyc_o(dst_cyc_b), .dst_stb_o(dst_stb_b),
    .dst_we_o(dst_we_b), .dst_sel_o(dst_sel_b), .dst_ack_i(dst_ack_b),
    .busy(busy_b), .done(done_b), .cpu_rst_o(cpu_rst_b)
  );

  int wr_b = 0, nseq_b = 0, ovl_b = 0;
  logic [31:0] log_adr_b [0:15];
  logic [31:0] log_dat_b [0:15];
  logic [31:0] seq_b     [0:15];

  assign src_ack_b = src_stb_b;
  assign src_dat_b = src_stb_b ? rom_word(src_adr_b) : 32'hBAD0_BAD0;
  assign dst_ack_b = dst_stb_b;

  always @(posedge clk) begin
    if (dst_stb_b && dst_ack_b) begin
      log_adr_b[wr_b[3:0]] <= dst_adr_b;
      log_dat_b[wr_b[3:0]] <= dst_dat_b;
      wr_b <= wr_b + 1;
    end
    if (src_stb_b && src_ack_b) begin
      seq_b[nseq_b[3:0]] <= src_adr_b;
      nseq_b <= nseq_b + 1;
    end
    if (src_stb_b && dst_stb_b) ovl_b <= ovl_b + 1;
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic restart_a();
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
  endtask

  task automatic run_a(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!done_a && n < 200);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_a = 1'b1;
    repeat (3) step();
    total++; if ({src_cyc_a, src_stb_a, src_we_a} !== 3'b000) $display("FAIL reset_src_ctl: got %b want 000", {src_cyc_a, src_stb_a, src_we_a}); else passed++;
    total++; if ({dst_cyc_a, dst_stb_a, dst_we_a} !== 3'b000) $display("FAIL reset_dst_ctl: got %b want 000", {dst_cyc_a, dst_stb_a, dst_we_a}); else passed++;
    total++; if (src_adr_a !== 32'h0) $display("FAIL reset_src_adr: got %h want 0", src_adr_a); else passed++;
    total++; if (dst_adr_a !== 32'h0) $display("FAIL reset_dst_adr: got %h want 0", dst_adr_a); else passed++;
    total++; if (dst_dat_a !== 32'h0) $display("FAIL reset_dst_dat: got %h want 0", dst_dat_a); else passed++;
    total++; if ({busy_a, done_a, cpu_rst_a} !== 3'b001) $display("FAIL reset_status: got %b want 001", {busy_a, done_a, cpu_rst_a}); else passed++;
    total++; if ({src_sel_a, dst_sel_a} !== 8'hFF) $display("FAIL reset_sel: got %h want ff", {src_sel_a, dst_sel_a}); else passed++;
  endtask

  task automatic test_zero_wait();
    int n, w0, o0;
    logic cpu_early;
    waits_a = 0; spur_a = 1'b0;
    restart_a();
    w0 = wr_a; o0 = ovl_a; cpu_early = 1'b0; n = 0;
    do begin
      step();
      n++;
      if (n == 1) begin
        total++; if ({src_stb_a, src_cyc_a, busy_a} !== 3'b111 || src_adr_a !== 32'h0)
          $display("FAIL zw_first_rd: got stb/cyc/busy=%b adr=%h want 111 adr=0", {src_stb_a, src_cyc_a, busy_a}, src_adr_a);
        else passed++;
      end
      if (!done_a && cpu_rst_a !== 1'b1) cpu_early = 1'b1;
    end while (!done_a && n < 200);
    total++; if (n !== 9) $display("FAIL zw_done_cycle: got %0d want 9", n); else passed++;
    total++; if ({cpu_rst_a, busy_a, cpu_early} !== 3'b000) $display("FAIL zw_cpu_rst: got cpu/busy/early=%b want 000", {cpu_rst_a, busy_a, cpu_early}); else passed++;
    total++; if (wr_a - w0 !== 4) $display("FAIL zw_writes: got %0d want 4", wr_a - w0); else passed++;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (log_adr_a[(w0 + k) % 64] !== DST + 32'(4 * k) || log_dat_a[(w0 + k) % 64] !== rom_word(32'(4 * k)))
        $display("FAIL zw_word%0d: got %h@%h want %h@%h", k, log_dat_a[(w0 + k) % 64], log_adr_a[(w0 + k) % 64], rom_word(32'(4 * k)), DST + 32'(4 * k));
      else passed++;
    end
    total++; if (ovl_a - o0 !== 0) $display("FAIL zw_overlap: got %0d want 0", ovl_a - o0); else passed++;
    repeat (3) step();
    total++; if ({done_a, src_stb_a, dst_stb_a, src_cyc_a, dst_cyc_a} !== 5'b10000)
      $display("FAIL zw_done_hold: got %b want 10000", {done_a, src_stb_a, dst_stb_a, src_cyc_a, dst_cyc_a});
    else passed++;
  endtask

  task automatic test_wait_states();
    int n, w0, o0, u0, b0;
    waits_a = 3; spur_a = 1'b0;
    restart_a();
    w0 = wr_a; o0 = ovl_a; u0 = unst_a; b0 = badwe_a;
    run_a(n);
    total++; if (n !== 21) $display("FAIL ws_done_cycle: got %0d want 21", n); else passed++;
    total++; if (unst_a - u0 !== 0) $display("FAIL ws_stable: got %0d changes want 0", unst_a - u0); else passed++;
    total++; if (ovl_a - o0 !== 0) $display("FAIL ws_overlap: got %0d want 0", ovl_a - o0); else passed++;
    total++; if (badwe_a - b0 !== 0) $display("FAIL ws_we: got %0d want 0", badwe_a - b0); else passed++;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (log_adr_a[(w0 + k) % 64] !== DST + 32'(4 * k) || log_dat_a[(w0 + k) % 64] !== rom_word(32'(4 * k)))
        $display("FAIL ws_word%0d: got %h@%h want %h@%h", k, log_dat_a[(w0 + k) % 64], log_adr_a[(w0 + k) % 64], rom_word(32'(4 * k)), DST + 32'(4 * k));
      else passed++;
    end
  endtask

  task automatic test_reset_midcopy();
    int n, w0;
    waits_a = 0; spur_a = 1'b0;
    restart_a();
    n = 0;
    do begin
      step();
      n++;
    end while (!(dst_stb_a && dst_adr_a == DST + 32'd8) && n < 50);
    total++; if (!(dst_stb_a && dst_adr_a == DST + 32'd8)) $display("FAIL mid_reach_wr2: got stb=%b adr=%h want 1 %h", dst_stb_a, dst_adr_a, DST + 32'd8); else passed++;
    rst_a = 1'b1;
    step();
    total++; if ({src_cyc_a, src_stb_a, dst_cyc_a, dst_stb_a, busy_a, done_a, cpu_rst_a} !== 7'b0000001)
      $display("FAIL mid_reset_state: got %b want 0000001", {src_cyc_a, src_stb_a, dst_cyc_a, dst_stb_a, busy_a, done_a, cpu_rst_a});
    else passed++;
    rst_a = 1'b0;
    w0 = wr_a;
    step();
    total++; if (src_stb_a !== 1'b1 || src_adr_a !== 32'h0) $display("FAIL mid_restart_adr: got stb=%b adr=%h want 1 0", src_stb_a, src_adr_a); else passed++;
    run_a(n);
    total++; if (n !== 8) $display("FAIL mid_done_cycle: got %0d want 8", n); else passed++;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (log_adr_a[(w0 + k) % 64] !== DST + 32'(4 * k) || log_dat_a[(w0 + k) % 64] !== rom_word(32'(4 * k)))
        $display("FAIL mid_word%0d: got %h@%h want %h@%h", k, log_dat_a[(w0 + k) % 64], log_adr_a[(w0 + k) % 64], rom_word(32'(4 * k)), DST + 32'(4 * k));
      else passed++;
    end
  endtask

  task automatic test_spurious_ack();
    int n, w0, u0;
    waits_a = 2; spur_a = 1'b1;
    restart_a();
    w0 = wr_a; u0 = unst_a;
    run_a(n);
    spur_a = 1'b0;
    total++; if (n !== 17) $display("FAIL sp_done_cycle: got %0d want 17", n); else passed++;
    total++; if (wr_a - w0 !== 4) $display("FAIL sp_writes: got %0d want 4", wr_a - w0); else passed++;
    total++; if (unst_a - u0 !== 0) $display("FAIL sp_stable: got %0d changes want 0", unst_a - u0); else passed++;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (log_dat_a[(w0 + k) % 64] !== rom_word(32'(4 * k)))
        $display("FAIL sp_word%0d: got %h want %h", k, log_dat_a[(w0 + k) % 64], rom_word(32'(4 * k)));
      else passed++;
    end
  endtask

  task automatic test_start_and_wrap();
    int n, w0, s0;
    logic idle_bad;
    logic [31:0] exp_adr [0:3];
    exp_adr[0] = 32'hFFFF_FFF8; exp_adr[1] = 32'hFFFF_FFFC;
    exp_adr[2] = 32'h0000_0000; exp_adr[3] = 32'h0000_0004;
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    idle_bad = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (src_stb_b || busy_b || !cpu_rst_b) idle_bad = 1'b1;
    end
    total++; if (idle_bad !== 1'b0) $display("FAIL st_idle_wait: got active=%b want 0", idle_bad); else passed++;
    w0 = wr_b; s0 = nseq_b;
    start_b = 1'b1;
    n = 0;
    do begin
      step();
      n++;
      start_b = (n == 3);
      if (n == 1) begin
        total++; if (src_stb_b !== 1'b1 || src_adr_b !== 32'hFFFF_FFF8)
          $display("FAIL st_first_rd: got stb=%b adr=%h want 1 fffffff8", src_stb_b, src_adr_b);
        else passed++;
      end
    end while (!done_b && n < 200);
    total++; if (n !== 9) $display("FAIL st_done_cycle: got %0d want 9", n); else passed++;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    repeat (5) step();
    total++; if ({done_b, busy_b, cpu_rst_b, src_stb_b, dst_stb_b} !== 5'b10000)
      $display("FAIL st_done_sticky: got %b want 10000", {done_b, busy_b, cpu_rst_b, src_stb_b, dst_stb_b});
    else passed++;
    total++; if (wr_b - w0 !== 4 || nseq_b - s0 !== 4) $display("FAIL st_once: got writes=%0d reads=%0d want 4 4", wr_b - w0, nseq_b - s0); else passed++;
    total++; if (ovl_b !== 0) $display("FAIL st_overlap: got %0d want 0", ovl_b); else passed++;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (seq_b[(s0 + k) % 16] !== exp_adr[k] || log_adr_b[(w0 + k) % 16] !== DST + 32'(4 * k) ||
          log_dat_b[(w0 + k) % 16] !== rom_word(exp_adr[k]))
        $display("FAIL wrap_word%0d: got src=%h dst=%h dat=%h want src=%h dst=%h dat=%h", k,
                 seq_b[(s0 + k) % 16], log_adr_b[(w0 + k) % 16], log_dat_b[(w0 + k) % 16],
                 exp_adr[k], DST + 32'(4 * k), rom_word(exp_adr[k]));
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_reset_midcopy();
    test_spurious_ack();
    test_start_and_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
